byteswap_stream: RTL and testbench

Streaming, parametrised successor to the fixed 32-bit byteswap datapath. It is a run-time selectable word-reorder engine (passthrough, byte swap, halfword swap, per-byte bit reverse) on a wide valid/ready stream. The block processes one transfer of a programmed beat count per ap_start, generates tlast, and reports ap_done/ap_idle. It sits between the AXI read master's data FIFO and the write master's data FIFO inside the kernel.

---
 rtl/byteswap_stream.sv | 130 +++++++++++++
 tb/tb_byteswap_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/byteswap_stream.sv
// Streaming word-reorder engine: passthrough, byte swap, halfword swap or per-byte
// bit reverse on a valid/ready stream, one programmed-length transfer per ap_start.
module byteswap_stream #(
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_WORD_BIT_WIDTH  = 32,
  parameter int C_BYTE_BIT_WIDTH  = 8,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  input  logic [1:0]                   mode,
  input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_beats,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [C_DATA_WIDTH-1:0]      s_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [C_DATA_WIDTH-1:0]      m_tdata,
  output logic                         m_tlast
);

  localparam int WB = C_WORD_BIT_WIDTH;
  localparam int BB = C_BYTE_BIT_WIDTH;
  localparam int NW = C_DATA_WIDTH / C_WORD_BIT_WIDTH;
  localparam int NB = C_WORD_BIT_WIDTH / C_BYTE_BIT_WIDTH;
  localparam int NH = C_WORD_BIT_WIDTH / (2 * C_BYTE_BIT_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   mode_q;
  logic [C_XFER_SIZE_WIDTH-1:0] beats_q;
  logic [C_XFER_SIZE_WIDTH-1:0] in_cnt_q;
  logic [C_XFER_SIZE_WIDTH-1:0] out_cnt_q;
  logic                         ap_idle_q, ap_done_q;
  logic                         s1_valid_q, s2_valid_q;
  logic [C_DATA_WIDTH-1:0]      s1_data_q, s2_data_q;
  logic [C_DATA_WIDTH-1:0]      xform;
  logic                         s1_adv, s2_adv, in_hs, out_hs, start_ok;

  assign s2_adv   = !s2_valid_q || m_tready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign s_tready = (state_q == RUN) && s1_adv;
  assign in_hs    = s_tvalid && s_tready;
  assign out_hs   = s2_valid_q && m_tready;
  assign start_ok = (state_q == IDLE) && ap_start;

  assign m_tvalid = s2_valid_q;
  assign m_tdata  = s2_data_q;
  // The stage-2 beat is beat number out_cnt_q+1 of the transfer.
  assign m_tlast  = s2_valid_q && ((out_cnt_q + C_XFER_SIZE_WIDTH'(1)) == beats_q);
  assign ap_idle  = ap_idle_q;
  assign ap_done  = ap_done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = (xfer_beats == '0) ? DONE : RUN;
      RUN:     if (in_hs && ((in_cnt_q + C_XFER_SIZE_WIDTH'(1)) == beats_q)) state_d = DRAIN;
      DRAIN:   if (out_hs && m_tlast) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q   <= IDLE;
      ap_idle_q <= 1'b1;
      ap_done_q <= 1'b0;
      mode_q    <= 2'd0;
      beats_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ap_idle_q <= (state_d == IDLE);
      ap_done_q <= (state_d == DONE);
      if (start_ok) begin
        mode_q    <= mode;
        beats_q   <= xfer_beats;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (in_hs)  in_cnt_q  <= in_cnt_q + C_XFER_SIZE_WIDTH'(1);
        if (out_hs) out_cnt_q <= out_cnt_q + C_XFER_SIZE_WIDTH'(1);
      end
    end
  end

  // Each word is reordered independently; word positions inside the beat never move.
  always_comb begin
    xform = s1_data_q;
    for (int w = 0; w < NW; w++) begin
      for (int j = 0; j < NB; j++) begin
        case (mode_q)
          2'd1: xform[w*WB + j*BB +: BB] = s1_data_q[w*WB + (NB-1-j)*BB +: BB];
          2'd2: xform[w*WB + j*BB +: BB] = s1_data_q[w*WB + ((NH-1-j/2)*2 + j%2)*BB +: BB];
          2'd3: begin
            for (int b = 0; b < BB; b++) begin
              xform[w*WB + j*BB + b] = s1_data_q[w*WB + j*BB + BB-1-b];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_hs;
        if (in_hs) s1_data_q <= s_tdata;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= xform;
      end
    end
  end

endmodule

// File: tb/tb_byteswap_stream.sv
// Directed bench for byteswap_stream: modes, streaming timing, backpressure,
// zero-length transfer, ignored mid-transfer start and reset recovery.
module tb_byteswap_stream;

  localparam int DW = 512;
  localparam int WW = 32;
  localparam int NW = DW / WW;
  localparam int XW = 32;

  logic          ap_clk = 1'b0;
  logic          areset, ap_start, ap_done, ap_idle;
  logic [1:0]    mode;
  logic [XW-1:0] xfer_beats;
  logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] s_tdata, m_tdata;

  int checkCount = 0;
  int errorCount = 0;

  always #5 ap_clk = ~ap_clk;

  byteswap_stream #(
    .C_DATA_WIDTH(DW), .C_WORD_BIT_WIDTH(WW), .C_BYTE_BIT_WIDTH(8), .C_XFER_SIZE_WIDTH(XW)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .mode(mode), .xfer_beats(xfer_beats),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] wordModel(input logic [1:0] md, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    case (md)
      2'd1: r = {w[7:0], w[15:8], w[23:16], w[31:24]};
      2'd2: r = {w[15:0], w[31:16]};
      2'd3: for (int i = 0; i < 32; i++) r[i] = w[(i/8)*8 + 7 - (i%8)];
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] beatModel(input logic [1:0] md, input logic [DW-1:0] beat);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*WW +: WW] = wordModel(md, beat[i*WW +: WW]);
    return r;
  endfunction

  function automatic logic [DW-1:0] beatIn(input int k, input bit constData, input logic [31:0] word);
    logic [DW-1:0] r;
    logic [15:0]   kk;
    kk = 16'(k);
    r  = '0;
    for (int i = 0; i < NW; i++)
      r[i*WW +: WW] = constData ? word : {kk[7:0], 8'(i), 8'hA5, kk[15:8]};
    return r;
  endfunction

  // Runs one transfer from a posedge+1 start point; ends at posedge+1.
  task automatic applyStimulus(input string name, input logic [1:0] md, input int beats,
                               input int readyPct, input bit constData,
                               input logic [31:0] inWord, input logic [31:0] expWord,
                               input bit checkTiming, input int disturbCyc,
                               input int resetAfter);
    int cyc = 0, inIdx = 0, outIdx = 0, budget;
    int firstAcc = -1, firstValid = -1, lastHs = -1, doneCyc = -1;
    int sreadyLate = 0, sreadySeen = 0, mvalidSeen = 0;
    bit prevStall = 1'b0, disturb;
    logic [DW-1:0] prevData, expBeat;
    logic prevLast;
    prevData = '0;
    prevLast = 1'b0;
    budget = 200 + 20 * beats;
    while (doneCyc < 0 && cyc < budget) begin
      disturb    = (disturbCyc >= 0) && (cyc >= disturbCyc) && (cyc < disturbCyc + 3);
      ap_start   = (cyc == 0) || disturb;
      mode       = disturb ? ~md : md;
      xfer_beats = disturb ? XW'(3) : XW'(beats);
      if (resetAfter >= 0 && inIdx == resetAfter) begin
        areset   = 1'b1;
        ap_start = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        checkOutput({name, "_rst_mvalid"}, DW'(m_tvalid), DW'(0));
        checkOutput({name, "_rst_sready"}, DW'(s_tready), DW'(0));
        checkOutput({name, "_rst_idle"}, DW'(ap_idle), DW'(1));
        checkOutput({name, "_rst_mtdata"}, m_tdata, '0);
        @(posedge ap_clk); #1;
        return;
      end
      s_tvalid = (inIdx < beats);
      s_tdata  = (inIdx < beats) ? beatIn(inIdx, constData, inWord) : '0;
      m_tready = (int'($urandom_range(99)) < readyPct);
      @(negedge ap_clk);
      if (s_tready) sreadySeen++;
      if (m_tvalid) mvalidSeen++;
      if (inIdx >= beats && s_tready) sreadyLate++;
      if (prevStall) begin
        checkOutput({name, "_stall_valid"}, DW'(m_tvalid), DW'(1));
        checkOutput({name, "_stall_data"}, m_tdata, prevData);
        checkOutput({name, "_stall_last"}, DW'(m_tlast), DW'(prevLast));
      end
      if (s_tvalid && s_tready) begin
        if (firstAcc < 0) firstAcc = cyc;
        inIdx++;
      end
      if (m_tvalid && firstValid < 0) firstValid = cyc;
      if (m_tvalid && m_tready) begin
        expBeat = constData ? {NW{expWord}} : beatModel(md, beatIn(outIdx, 1'b0, 32'h0));
        checkOutput({name, "_data"}, m_tdata, expBeat);
        checkOutput({name, "_tlast"}, DW'(m_tlast), DW'(outIdx == beats - 1));
        outIdx++;
        lastHs = cyc;
      end
      prevStall = m_tvalid && !m_tready;
      prevData  = m_tdata;
      prevLast  = m_tlast;
      if (ap_done) doneCyc = cyc;
      @(posedge ap_clk); #1;
      cyc++;
    end
    ap_start = 1'b0;
    s_tvalid = 1'b0;
    checkOutput({name, "_done_seen"}, DW'(doneCyc >= 0), DW'(1));
    checkOutput({name, "_beats_out"}, DW'(outIdx), DW'(beats));
    if (beats > 0) begin
      checkOutput({name, "_done_lat"}, DW'(doneCyc - lastHs), DW'(1));
    end else begin
      checkOutput({name, "_done_win"}, DW'(doneCyc >= 1 && doneCyc <= 2), DW'(1));
      checkOutput({name, "_no_sready"}, DW'(sreadySeen), DW'(0));
      checkOutput({name, "_no_mvalid"}, DW'(mvalidSeen), DW'(0));
    end
    if (checkTiming) begin
      checkOutput({name, "_latency"}, DW'(firstValid - firstAcc), DW'(2));
      checkOutput({name, "_back2back"}, DW'(lastHs - firstValid), DW'(beats - 1));
      checkOutput({name, "_sready_after"}, DW'(sreadyLate), DW'(0));
    end
    @(negedge ap_clk);
    checkOutput({name, "_done_pulse"}, DW'(ap_done), DW'(0));
    checkOutput({name, "_idle_back"}, DW'(ap_idle), DW'(1));
    @(posedge ap_clk); #1;
  endtask

  initial begin
    areset     = 1'b1;
    ap_start   = 1'b0;
    mode       = 2'd0;
    xfer_beats = '0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    m_tready   = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 areset = 1'b0;
    @(negedge ap_clk);
    checkOutput("reset_idle", DW'(ap_idle), DW'(1));
    checkOutput("reset_done", DW'(ap_done), DW'(0));
    checkOutput("reset_sready", DW'(s_tready), DW'(0));
    checkOutput("reset_mvalid", DW'(m_tvalid), DW'(0));
    checkOutput("reset_tlast", DW'(m_tlast), DW'(0));
    checkOutput("reset_mtdata", m_tdata, '0);
    @(posedge ap_clk); #1;

    applyStimulus("mode0", 2'd0, 1, 100, 1'b1, 32'h11223344, 32'h11223344, 1'b0, -1, -1);
    applyStimulus("mode1", 2'd1, 1, 100, 1'b1, 32'h11223344, 32'h44332211, 1'b0, -1, -1);
    applyStimulus("mode2", 2'd2, 1, 100, 1'b1, 32'h11223344, 32'h33441122, 1'b0, -1, -1);
    applyStimulus("mode3", 2'd3, 1, 100, 1'b1, 32'h11223344, 32'h8844CC22, 1'b0, -1, -1);
    applyStimulus("stream16", 2'd1, 16, 100, 1'b0, 32'h0, 32'h0, 1'b1, -1, -1);
    applyStimulus("bp100", 2'd3, 100, 30, 1'b0, 32'h0, 32'h0, 1'b0, -1, -1);
    applyStimulus("zero", 2'd1, 0, 100, 1'b0, 32'h0, 32'h0, 1'b0, -1, -1);
    applyStimulus("ignore", 2'd1, 8, 50, 1'b0, 32'h0, 32'h0, 1'b0, 4, -1);
    applyStimulus("abort", 2'd1, 10, 100, 1'b0, 32'h0, 32'h0, 1'b0, -1, 5);
    applyStimulus("after_rst", 2'd2, 3, 100, 1'b0, 32'h0, 32'h0, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
